// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing source. Free-running horizontal/vertical
//               counters gated by a pixel enable. Sync pulses, active flags
//               and line/frame strobes are registered alongside the counters,
//               so every output describes the pixel currently on hpos/vpos.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_NEG = 1'b1
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       ena,
    output logic [9:0] hpos,
    output logic [8:0] vpos,
    output logic       hactive,
    output logic       vactive,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_end,
    output logic       frame_end
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Idle level of both sync outputs
    localparam logic SYNC_OFF = SYNC_NEG;

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] hcount_next;
    logic [9:0] vcount_next;

    logic hactive_next;
    logic vactive_next;
    logic hsync_next;
    logic vsync_next;
    logic line_end_next;
    logic frame_end_next;

    // Next raster position: horizontal wraps each line, vertical steps on the wrap
    always_comb begin
        hcount_next = hcount + 10'd1;
        vcount_next = vcount;
        if (hcount == H_LAST) begin
            hcount_next = '0;
            vcount_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end
    end

    // Decode flags from the next position so they land in the same register stage
    always_comb begin
        hactive_next   = (hcount_next < H_ACT_END);
        vactive_next   = (vcount_next < V_ACT_END);
        hsync_next     = ((hcount_next >= HS_START) && (hcount_next < HS_END)) ? ~SYNC_OFF : SYNC_OFF;
        vsync_next     = ((vcount_next >= VS_START) && (vcount_next < VS_END)) ? ~SYNC_OFF : SYNC_OFF;
        line_end_next  = (hcount_next == H_LAST);
        frame_end_next = (hcount_next == H_LAST) && (vcount_next == V_LAST);
    end

    // Counters and all outputs advance together, only on enabled pixels
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hcount     <= '0;
            vcount     <= '0;
            hactive    <= 1'b1;
            vactive    <= 1'b1;
            display_on <= 1'b1;
            hsync      <= SYNC_OFF;
            vsync      <= SYNC_OFF;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
        end else if (ena) begin
            hcount     <= hcount_next;
            vcount     <= vcount_next;
            hactive    <= hactive_next;
            vactive    <= vactive_next;
            display_on <= hactive_next && vactive_next;
            hsync      <= hsync_next;
            vsync      <= vsync_next;
            line_end   <= line_end_next;
            frame_end  <= frame_end_next;
        end
    end

    // vpos deliberately exposes only the low 9 bits; lines 512..524 alias 0..12
    assign hpos = hcount;
    assign vpos = vcount[8:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Three instances:
//               full 640x480 timing, a narrow-line variant (16-pixel lines,
//               full 525-line frame) and the same with active-high syncs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk  = 1'b0;
    logic nRst = 1'b1;
    logic ena  = 1'b0;

    logic [9:0] hpos [3];
    logic [8:0] vpos [3];
    logic       hact [3];
    logic       vact [3];
    logic       disp [3];
    logic       hs   [3];
    logic       vs   [3];
    logic       le   [3];
    logic       fe   [3];

    int checks = 0;
    int errors = 0;
    int n_f = 0;    // pixel index within frame, full-size instance
    int n_s = 0;    // pixel index within frame, narrow-line instances

    always #5 clk = ~clk;

    vga_timing_gen u_full (
        .clk(clk), .nRst(nRst), .ena(ena),
        .hpos(hpos[0]), .vpos(vpos[0]), .hactive(hact[0]), .vactive(vact[0]),
        .display_on(disp[0]), .hsync(hs[0]), .vsync(vs[0]),
        .line_end(le[0]), .frame_end(fe[0])
    );

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3)) u_small (
        .clk(clk), .nRst(nRst), .ena(ena),
        .hpos(hpos[1]), .vpos(vpos[1]), .hactive(hact[1]), .vactive(vact[1]),
        .display_on(disp[1]), .hsync(hs[1]), .vsync(vs[1]),
        .line_end(le[1]), .frame_end(fe[1])
    );

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .SYNC_NEG(1'b0)) u_pos (
        .clk(clk), .nRst(nRst), .ena(ena),
        .hpos(hpos[2]), .vpos(vpos[2]), .hactive(hact[2]), .vactive(vact[2]),
        .display_on(disp[2]), .hsync(hs[2]), .vsync(vs[2]),
        .line_end(le[2]), .frame_end(fe[2])
    );

    // Reference: expected outputs for linear pixel index n of the frame
    function automatic logic [25:0] model(input int n, input int ha, input int hf, input int hsw,
                                          input int hb, input int va, input int vf, input int vsw,
                                          input int vb, input bit neg);
        int  ht, vt, hc, vc;
        logic a_h, a_v, s_h, s_v, l_e, f_e;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        hc  = n % ht;
        vc  = n / ht;
        a_h = (hc < ha);
        a_v = (vc < va);
        s_h = (hc >= ha + hf) && (hc < ha + hf + hsw);
        s_v = (vc >= va + vf) && (vc < va + vf + vsw);
        l_e = (hc == ht - 1);
        f_e = l_e && (vc == vt - 1);
        return {10'(hc), 9'(vc % 512), a_h, a_v, a_h && a_v,
                neg ? ~s_h : s_h, neg ? ~s_v : s_v, l_e, f_e};
    endfunction

    function automatic logic [25:0] expected(input int i);
        case (i)
            0:       return model(n_f, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
            1:       return model(n_s, 8, 2, 3, 3, 480, 10, 2, 33, 1'b1);
            default: return model(n_s, 8, 2, 3, 3, 480, 10, 2, 33, 1'b0);
        endcase
    endfunction

    function automatic logic [25:0] actual(input int i);
        return {hpos[i], vpos[i], hact[i], vact[i], disp[i], hs[i], vs[i], le[i], fe[i]};
    endfunction

    task automatic check_all(input string tag);
        logic [25:0] e, a;
        for (int i = 0; i < 3; i++) begin
            e = expected(i);
            a = actual(i);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s dut%0d n=%0d: got %h, expected %h", tag, i,
                         (i == 0) ? n_f : n_s, a, e);
            end
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given enable; model advances on the edge, outputs checked mid-cycle
    task automatic step(input logic e);
        ena = e;
        @(posedge clk);
        if (nRst && e) begin
            n_f = (n_f + 1) % 420000;
            n_s = (n_s + 1) % 8400;
        end
        @(negedge clk);
        check_all("model");
    endtask

    // Called on a falling clock edge; reset must act immediately, not on the next edge
    task automatic apply_reset(input int cycles);
        nRst = 1'b0;
        #1;
        n_f = 0;
        n_s = 0;
        check_all("async_reset");
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            check_all("in_reset");
        end
        nRst = 1'b1;
    endtask

    typedef struct {
        int         adv;
        logic [9:0] hp;
        logic [8:0] vp;
        logic       ha;
        logic       hsy;
        logic       lend;
    } vec_t;

    initial begin
        vec_t tbl [9];
        int   k, lines, c, lh;
        logic t;

        // Full-size line timing: cycles to advance, then expected state
        tbl = '{
            '{0,   10'd0,   9'd0, 1'b1, 1'b1, 1'b0},
            '{639, 10'd639, 9'd0, 1'b1, 1'b1, 1'b0},
            '{1,   10'd640, 9'd0, 1'b0, 1'b1, 1'b0},
            '{15,  10'd655, 9'd0, 1'b0, 1'b1, 1'b0},
            '{1,   10'd656, 9'd0, 1'b0, 1'b0, 1'b0},
            '{95,  10'd751, 9'd0, 1'b0, 1'b0, 1'b0},
            '{1,   10'd752, 9'd0, 1'b0, 1'b1, 1'b0},
            '{47,  10'd799, 9'd0, 1'b0, 1'b1, 1'b1},
            '{1,   10'd0,   9'd1, 1'b1, 1'b1, 1'b0}
        };

        @(negedge clk);
        apply_reset(2);
        checks++;
        if ({hact[0], vact[0], disp[0], hs[0], vs[0], le[0], fe[0]} !== 7'b1111100) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 1111100",
                     {hact[0], vact[0], disp[0], hs[0], vs[0], le[0], fe[0]});
        end

        for (int i = 0; i < 9; i++) begin
            repeat (tbl[i].adv) step(1'b1);
            checks++;
            if ({hpos[0], vpos[0], hact[0], hs[0], le[0]} !==
                {tbl[i].hp, tbl[i].vp, tbl[i].ha, tbl[i].hsy, tbl[i].lend}) begin
                errors++;
                $display("FAIL line_vec%0d: got hpos=%0d vpos=%0d hact=%b hs=%b le=%b, expected %0d %0d %b %b %b",
                         i, hpos[0], vpos[0], hact[0], hs[0], le[0],
                         tbl[i].hp, tbl[i].vp, tbl[i].ha, tbl[i].hsy, tbl[i].lend);
            end
        end

        // First frame_end after reset on the narrow-line instance
        apply_reset(1);
        k = 0;
        while (!fe[1] && k < 20000) begin
            step(1'b1);
            k++;
        end
        check_int("first_frame_end_cycles", k, 8399);
        check_int("frame_end_hpos", int'(hpos[1]), 15);
        check_int("frame_end_vpos", int'(vpos[1]), 12);
        step(1'b1);
        check_int("frame_wrap_pos", int'({hpos[1], vpos[1]}), 0);

        // Full frame period, line count, alias and vsync windows
        k = 1;
        lines = 0;
        while (!fe[1] && k < 20000) begin
            step(1'b1);
            k++;
            if (le[1]) lines++;
            if (k - 1 == 489 * 16 + 15) check_int("vsync_before", int'({vs[1], vs[2]}), 2);
            if (k - 1 == 490 * 16)      check_int("vsync_start", int'({vs[1], vs[2]}), 1);
            if (k - 1 == 491 * 16 + 15) check_int("vsync_last", int'({vs[1], vs[2]}), 1);
            if (k - 1 == 492 * 16)      check_int("vsync_end", int'({vs[1], vs[2]}), 2);
            if (k - 1 == 512 * 16)      check_int("alias_512", int'({vpos[1], vact[1]}), 0);
            if (k - 1 == 524 * 16)      check_int("alias_524", int'({vpos[1], vact[1]}), 24);
        end
        check_int("frame_period", k, 8400);
        check_int("lines_per_frame", lines, 525);

        // Enable toggling: state holds on idle cycles, period doubles
        c  = 0;
        lh = 0;
        t  = 1'b1;
        do begin
            t = ~t;
            step(t);
            c++;
            if (t && le[1]) lh++;
        end while (!(t && fe[1]) && c < 40000);
        check_int("toggle_frame_period", c, 16800);
        check_int("toggle_line_strobes", lh, 525);

        // Reset mid-frame at line 200, pixel 5, held for 3 clocks
        k = 0;
        while (n_s != 200 * 16 + 5 && k < 20000) begin
            step(1'b1);
            k++;
        end
        apply_reset(3);
        check_int("midreset_pos", int'({hpos[1], vpos[1], hs[1], vs[1]}), 3);
        k = 0;
        while (!fe[1] && k < 20000) begin
            step(1'b1);
            k++;
        end
        check_int("post_reset_frame_end", k, 8399);

        // Randomised enable with occasional resets against the reference
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) apply_reset(int'($urandom_range(1, 3)));
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
